// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the IF stage: FSM state encoding, default
// reset PC, bubble instruction and HLT opcode, plus the HLT decode helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH     = 2'b00,
    MISS_WAIT = 2'b01,
    HALTED    = 2'b10
  } fetch_state_t;

  localparam logic [15:0] DEF_RESET_PC    = 16'h0000;
  localparam logic [15:0] DEF_NOP_INSTR   = 16'h0000;
  localparam logic [3:0]  DEF_HALT_OPCODE = 4'hF;

  // True when the instruction word carries the HLT opcode in [15:12].
  function automatic logic is_halt(input logic [15:0] instr, input logic [3:0] halt_op);
    return instr[15:12] == halt_op;
  endfunction

endpackage

// File: rtl/adder_sub_16bit.sv
// 16-bit modulo adder/subtractor: sum = a + b (is_sub=0) or a - b (is_sub=1).
module adder_sub_16bit (
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        is_sub,
  output logic [15:0] sum
);

  // Two's-complement subtract by inverting b and injecting a carry-in.
  always_comb begin
    sum = a + (b ^ {16{is_sub}}) + {15'd0, is_sub};
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 16-bit five-stage pipeline: PC register, I-memory read
// port, IF/ID register, miss handling with deferred redirect, HLT stop.
// Optional build macro FETCH_PERF_CNT_EN adds saturating perf counters
// perf_fetch_cnt (valid IF/ID writes) and perf_miss_cyc (MISS_WAIT cycles).
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [15:0] RESET_PC    = DEF_RESET_PC,
  parameter logic [15:0] NOP_INSTR   = DEF_NOP_INSTR,
  parameter logic [3:0]  HALT_OPCODE = DEF_HALT_OPCODE
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall_if,
  input  logic        branch_taken,
  input  logic [15:0] branch_target,
  output logic        imem_rd_en,
  output logic [15:0] imem_addr,
  input  logic [15:0] imem_data,
  input  logic        imem_ready,
  output logic [15:0] pc_out,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_pc,
  output logic [15:0] if_id_pc_plus2,
  output logic        if_id_valid,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_miss_cyc
`endif
);

  fetch_state_t state_q, state_d;
  logic [15:0]  pc_q, pc_d, pc_plus2;
  logic         pend_valid_q, pend_valid_d;
  logic [15:0]  pend_target_q, pend_target_d;
  logic         ifid_capture, ifid_bubble;

  adder_sub_16bit u_pc_inc (
    .a      (pc_q),
    .b      (16'd2),
    .is_sub (1'b0),
    .sum    (pc_plus2)
  );

  assign pc_out     = pc_q;
  assign imem_addr  = pc_q;
  assign imem_rd_en = (state_q != HALTED);
  assign halted     = (state_q == HALTED);

  // Next-state, next-PC, pending-redirect and IF/ID load decisions.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d       = state_q;
    pc_d          = pc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    ifid_capture  = 1'b0;
    ifid_bubble   = 1'b0;
    unique case (state_q)
      FETCH: begin
        if (branch_taken) begin
          pc_d        = branch_target;
          ifid_bubble = 1'b1;
        end else if (stall_if) begin
          // Hold everything; the same PC is presented again next cycle.
        end else if (imem_ready) begin
          ifid_capture = 1'b1;
          if (is_halt(imem_data, HALT_OPCODE)) state_d = HALTED;
          else                                 pc_d    = pc_plus2;
        end else begin
          ifid_bubble = 1'b1;
          state_d     = MISS_WAIT;
        end
      end
      MISS_WAIT: begin
        ifid_bubble = !stall_if;
        // A redirect during a miss is deferred; the newest target wins.
        if (branch_taken) begin
          pend_valid_d  = 1'b1;
          pend_target_d = branch_target;
        end
        if (imem_ready) begin
          if (pend_valid_d) begin
            pc_d         = pend_target_d;
            pend_valid_d = 1'b0;
            state_d      = FETCH;
          end else if (stall_if) begin
            state_d = FETCH;
          end else begin
            ifid_bubble  = 1'b0;
            ifid_capture = 1'b1;
            if (is_halt(imem_data, HALT_OPCODE)) state_d = HALTED;
            else begin
              pc_d    = pc_plus2;
              state_d = FETCH;
            end
          end
        end
      end
      HALTED: begin
        ifid_bubble = !stall_if;
        // An older branch squashes the HLT and restarts fetch.
        if (branch_taken) begin
          pc_d    = branch_target;
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
  end

  // FSM state, PC and pending-redirect registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      pend_valid_q  <= 1'b0;
      pend_target_q <= 16'h0000;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update together at the edge.
      state_q       <= state_d;
      pc_q          <= pc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
    end
  end

  // IF/ID pipeline register: capture, bubble, or hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 16'h0000;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
    end else if (ifid_capture) begin
      if_id_instr    <= imem_data;
      if_id_pc       <= pc_q;
      if_id_pc_plus2 <= pc_plus2;
      if_id_valid    <= 1'b1;
    end else if (ifid_bubble) begin
      if_id_instr    <= NOP_INSTR;
      if_id_pc       <= 16'h0000;
      if_id_pc_plus2 <= 16'h0000;
      if_id_valid    <= 1'b0;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating counters: valid IF/ID writes and cycles spent in MISS_WAIT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= 16'h0000;
      perf_miss_cyc  <= 16'h0000;
    end else begin
      if (ifid_capture && perf_fetch_cnt != 16'hFFFF)
        perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (state_q == MISS_WAIT && perf_miss_cyc != 16'hFFFF)
        perf_miss_cyc <= perf_miss_cyc + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: each directed cycle pushes the expected
// post-edge state; a monitor pops and compares one entry after every edge.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        stall_if = 1'b1;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_target = 16'h0000;
  logic        imem_rd_en;
  logic [15:0] imem_addr;
  logic [15:0] imem_data = 16'h0000;
  logic        imem_ready = 1'b0;
  logic [15:0] pc_out;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_pc;
  logic [15:0] if_id_pc_plus2;
  logic        if_id_valid;
  logic        halted;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          id;
    logic [15:0] pc;
    logic [15:0] instr;
    logic [15:0] ipc;
    logic [15:0] ipc2;
    logic        valid;
    logic        halted;
  } exp_t;

  exp_t exp_q[$];

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .stall_if       (stall_if),
    .branch_taken   (branch_taken),
    .branch_target  (branch_target),
    .imem_rd_en     (imem_rd_en),
    .imem_addr      (imem_addr),
    .imem_data      (imem_data),
    .imem_ready     (imem_ready),
    .pc_out         (pc_out),
    .if_id_instr    (if_id_instr),
    .if_id_pc       (if_id_pc),
    .if_id_pc_plus2 (if_id_pc_plus2),
    .if_id_valid    (if_id_valid),
    .halted         (halted)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the state expected after the next edge.
  task automatic cyc(input int id, input logic st, input logic br, input logic [15:0] tgt,
                     input logic rdy, input logic [15:0] data,
                     input logic [15:0] e_pc, input logic [15:0] e_instr,
                     input logic [15:0] e_ipc, input logic [15:0] e_ipc2,
                     input logic e_valid, input logic e_halted);
    exp_t e;
    @(negedge clk);
    stall_if      = st;
    branch_taken  = br;
    branch_target = tgt;
    imem_ready    = rdy;
    imem_data     = data;
    e.id = id; e.pc = e_pc; e.instr = e_instr; e.ipc = e_ipc; e.ipc2 = e_ipc2;
    e.valid = e_valid; e.halted = e_halted;
    exp_q.push_back(e);
  endtask

  task automatic idle_inputs();
    stall_if     = 1'b1;
    branch_taken = 1'b0;
    imem_ready   = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " pc_out"},      pc_out, 16'h0000);
    check({tag, " imem_addr"},   imem_addr, 16'h0000);
    check({tag, " instr"},       if_id_instr, 16'h0000);
    check({tag, " if_pc"},       if_id_pc, 16'h0000);
    check({tag, " if_pc2"},      if_id_pc_plus2, 16'h0000);
    check({tag, " valid"},       {15'd0, if_id_valid}, 16'd0);
    check({tag, " halted"},      {15'd0, halted}, 16'd0);
    check({tag, " rd_en"},       {15'd0, imem_rd_en}, 16'd1);
  endtask

  // Monitor: after each rising edge, compare DUT state to the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("c%0d pc_out", e.id),    pc_out, e.pc);
        check($sformatf("c%0d imem_addr", e.id), imem_addr, e.pc);
        check($sformatf("c%0d instr", e.id),     if_id_instr, e.instr);
        check($sformatf("c%0d valid", e.id),     {15'd0, if_id_valid}, {15'd0, e.valid});
        check($sformatf("c%0d halted", e.id),    {15'd0, halted}, {15'd0, e.halted});
        check($sformatf("c%0d rd_en", e.id),     {15'd0, imem_rd_en}, {15'd0, !e.halted});
        if (e.valid) begin
          check($sformatf("c%0d if_pc", e.id),  if_id_pc, e.ipc);
          check($sformatf("c%0d if_pc2", e.id), if_id_pc_plus2, e.ipc2);
        end
      end
    end
  end

  initial begin
    // Initial reset.
    #1 rst_n = 1'b0;
    #1 check_reset_values("rst0");
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    //   id  st br tgt      rdy data      pc       instr    ipc      ipc2     v  h
    // Sequential hits.
    cyc(1,  0, 0, 16'h0000, 1, 16'h1234, 16'h0002, 16'h1234, 16'h0000, 16'h0002, 1, 0);
    cyc(2,  0, 0, 16'h0000, 1, 16'h2345, 16'h0004, 16'h2345, 16'h0002, 16'h0004, 1, 0);
    cyc(3,  0, 0, 16'h0000, 1, 16'h3456, 16'h0006, 16'h3456, 16'h0004, 16'h0006, 1, 0);
    // Redirect at pc 0x0006: wrong-path data squashed.
    cyc(4,  0, 1, 16'h0040, 1, 16'h9999, 16'h0040, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(5,  0, 0, 16'h0000, 1, 16'h4444, 16'h0042, 16'h4444, 16'h0040, 16'h0042, 1, 0);
    // Miss at 0x0010 with a redirect arriving during the miss.
    cyc(6,  0, 1, 16'h0010, 1, 16'h9999, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(7,  0, 0, 16'h0000, 0, 16'h9999, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(8,  0, 1, 16'h0080, 0, 16'h9999, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(9,  0, 0, 16'h0000, 0, 16'h9999, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(10, 0, 0, 16'h0000, 1, 16'h5555, 16'h0080, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(11, 0, 0, 16'h0000, 1, 16'h6666, 16'h0082, 16'h6666, 16'h0080, 16'h0082, 1, 0);
    // HLT at 0x0020, then a squashing branch to 0x0030.
    cyc(12, 0, 1, 16'h0020, 1, 16'h9999, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(13, 0, 0, 16'h0000, 1, 16'hF000, 16'h0020, 16'hF000, 16'h0020, 16'h0022, 1, 1);
    cyc(14, 0, 0, 16'h0000, 1, 16'h7777, 16'h0020, 16'h0000, 16'h0000, 16'h0000, 0, 1);
    cyc(15, 0, 1, 16'h0030, 1, 16'h7777, 16'h0030, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(16, 0, 0, 16'h0000, 1, 16'h1111, 16'h0032, 16'h1111, 16'h0030, 16'h0032, 1, 0);
    // Two-cycle stall with a hit available: hold, then capture exactly once.
    cyc(17, 1, 0, 16'h0000, 1, 16'h2222, 16'h0032, 16'h1111, 16'h0030, 16'h0032, 1, 0);
    cyc(18, 1, 0, 16'h0000, 1, 16'h2222, 16'h0032, 16'h1111, 16'h0030, 16'h0032, 1, 0);
    cyc(19, 0, 0, 16'h0000, 1, 16'h2222, 16'h0034, 16'h2222, 16'h0032, 16'h0034, 1, 0);
    cyc(20, 0, 0, 16'h0000, 1, 16'h3333, 16'h0036, 16'h3333, 16'h0034, 16'h0036, 1, 0);
    // Miss completing under stall: data dropped, same PC re-fetched.
    cyc(21, 0, 0, 16'h0000, 0, 16'h9999, 16'h0036, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(22, 1, 0, 16'h0000, 1, 16'h4444, 16'h0036, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(23, 0, 0, 16'h0000, 1, 16'h4545, 16'h0038, 16'h4545, 16'h0036, 16'h0038, 1, 0);
    // PC wrap from 0xFFFE.
    cyc(24, 0, 1, 16'hFFFE, 1, 16'h9999, 16'hFFFE, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(25, 0, 0, 16'h0000, 1, 16'h5656, 16'h0000, 16'h5656, 16'hFFFE, 16'h0000, 1, 0);
    // Enter MISS_WAIT at 0x00FE with a pending redirect, then reset mid-cycle.
    cyc(26, 0, 1, 16'h00FE, 1, 16'h9999, 16'h00FE, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(27, 0, 0, 16'h0000, 0, 16'h9999, 16'h00FE, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(28, 0, 1, 16'h0200, 0, 16'h9999, 16'h00FE, 16'h0000, 16'h0000, 16'h0000, 0, 0);

    @(posedge clk);
    #2;
    idle_inputs();
    rst_n = 1'b0;
    #1 check_reset_values("async_rst");
    @(negedge clk);
    rst_n = 1'b1;

    // After reset: a miss must not pick up the old pending redirect.
    cyc(29, 0, 0, 16'h0000, 0, 16'h9999, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0);
    cyc(30, 0, 0, 16'h0000, 1, 16'h7171, 16'h0002, 16'h7171, 16'h0000, 16'h0002, 1, 0);

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
